mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the dual-issue in-order pipeline. Sits directly downstream of the execute stage.
- Latches one execute-stage result per slot and waits for the data-SRAM data_ok response of a request already accepted (addr_ok) upstream.
- Sign/zero-extends load data, buffers it if writeback stalls, and drives forwarding, stall and exception signals back toward execute/decode.

Parameters:
- DATA_W, 32, data/address width.
- RADDR_W, 5, register-file address width.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- ex_to_mem_valid_i  in  1  execute result valid (execute ready_go qualified).
- mem_allowin_o  out  1  stage may accept new entry.
- ex_mem_req_i  in  1  entry issued a data-SRAM request that received addr_ok.
- ex_mem_we_i  in  1  request was a store.
- ex_data_src_i  in  3  {byte, half, unsigned} load/store width code.
- ex_regs_wdata_src_i  in  1  1 = register result comes from load data.
- ex_addr_low2_i  in  2  low address bits of the access.
- ex_regs_we_i  in  1  register write enable.
- ex_regs_waddr_i  in  RADDR_W  destination register.
- ex_regs_wdata_i  in  DATA_W  ALU/CSR result.
- ex_pc_i  in  PC_W  instruction PC.
- ex_excep_en_i  in  1  entry carries an exception.
- data_sram_data_ok_i  in  1  response for oldest outstanding request.
- data_sram_rdata_i  in  DATA_W  read data, valid with data_ok.
- wb_allowin_i  in  1  writeback accepts.
- excep_flush_i  in  1  pipeline flush from writeback.
- mem_to_wb_valid_o  out  1  result valid toward writeback.
- wb_regs_we_o  out  1  write enable toward writeback.
- wb_regs_waddr_o  out  RADDR_W  destination register toward writeback.
- wb_regs_wdata_o  out  DATA_W  final register data.
- wb_pc_o  out  PC_W  PC toward writeback.
- wb_excep_en_o  out  1  exception flag toward writeback.
- mem_stall_o  out  1  to execute: hold store/writes (valid entry with exception).
- fwd_we_o  out  1  forwarding write enable.
- fwd_waddr_o  out  RADDR_W  forwarding register address.
- fwd_wdata_o  out  DATA_W  forwarding data.
- fwd_stall_o  out  1  forwarding data not yet available (load pending).

Behaviour:
- Reset: valid=0, state=IDLE, discard_cnt=0. All outputs 0 except mem_allowin_o=1.
- Entry register loads when ex_to_mem_valid_i && mem_allowin_o.
- mem_allowin_o = !valid || (ready_go && wb_allowin_i).
- State machine:
  - IDLE: no outstanding response.
  - WAIT: entered on load of an entry with ex_mem_req_i=1.
  - HAVE: reached from WAIT on data_ok; rdata captured into buffer.
  - HAVE/WAIT→IDLE (or WAIT again if the next entry has a request) on handoff to writeback.
- ready_go = !ex_mem_req_i_latched || state==HAVE || (state==WAIT && data_ok && discard_cnt==0).
  - A data_ok in WAIT with wb_allowin_i=1 hands off the same cycle, zero-bubble.
- Stores also wait for data_ok; no data captured.
- Load extension selected by the latched data_src and addr_low2:
  - byte: lane = addr_low2, sign-extend unless unsigned bit set.
  - half: lane = addr_low2[1].
  - word: pass through.
- wb_regs_wdata_o = regs_wdata_src ? extended load : latched wdata.
- wb_regs_we_o = regs_we && valid && !excep_en && !excep_flush_i.
- mem_stall_o = valid && excep_en.
- fwd_*: we/waddr/wdata from the entry; fwd_stall_o = valid && regs_wdata_src && state!=HAVE.
- Flush (excep_flush_i): valid clears next cycle.
  - If state==WAIT and no data_ok this cycle, discard_cnt increments (2-bit saturating at 3).
  - Each data_ok with discard_cnt>0 decrements it and is not treated as this entry's response.
  - mem_allowin_o stays 1 during discard.
  - A new request-bearing entry reaching WAIT while discard_cnt>0 waits for the counter to reach 0 first.
- Simultaneous data_ok and flush in WAIT: response consumed, counter unchanged.
- Exception entries never carry mem_req; they pass through in one cycle.

Optional Feature:
- MEM_LOAD_FWD_EN
  - Defined: in the data_ok cycle, fwd_wdata_o = extended rdata and fwd_stall_o=0.
  - Undefined: fwd_stall_o stays asserted until state==HAVE or handoff.

Decomposition:
- Shared package/header holds:
  - data_src bit positions (BYTE=2, HALF=1, UNSIGNED=0).
  - state encodings IDLE=0, WAIT=1, HAVE=2.
  - discard counter width.
- One natural sub-module: load_extend, combinational (rdata, addr_low2, data_src → DATA_W result).

Test Plan:
- ld.b, addr_low2=2'b11, rdata=32'h80AB_CD12, data_ok 1 cycle later, wb_allowin=1 → wb_regs_wdata_o=32'hFFFF_FF80, mem_to_wb_valid_o for 1 cycle.
- ld.hu, addr_low2=2'b10, rdata=32'h8765_4321, data_ok arrives while wb_allowin=0 for 3 cycles → buffered; on wb_allowin=1 output 32'h0000_8765, fwd_stall_o=0 from cycle after data_ok.
- Non-memory ALU entry, wdata=32'h1234 → ready_go same cycle, handed to writeback next edge, fwd_stall_o=0.
- Load in WAIT, excep_flush_i pulse, then data_ok with rdata=32'hDEAD_BEEF while a new load enters → discarded, new load waits for its own data_ok, returns its own data.
- Entry with ex_excep_en_i=1 → mem_stall_o=1, wb_regs_we_o=0, wb_excep_en_o=1.
- Assert rst mid-WAIT → all outputs to reset values immediately (async), state=IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the load/store width code bit positions, the response-tracking
// state encoding, the discard counter width and the latched control bundle.
package mem_stage_pkg;

   // Bit positions inside the 3-bit {byte, half, unsigned} width code
   localparam int DS_W        = 3;
   localparam int DS_BYTE     = 2;
   localparam int DS_HALF     = 1;
   localparam int DS_UNSIGNED = 0;

   // Counts responses still owed to entries that were flushed while waiting
   localparam int                    DISCARD_W   = 2;
   localparam logic [DISCARD_W-1:0] DISCARD_MAX = 2'd3;
   localparam logic [DISCARD_W-1:0] DISCARD_ONE = 2'd1;
   localparam logic [DISCARD_W-1:0] DISCARD_ZERO = 2'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no response outstanding for the held entry
      ST_WAIT = 2'd1,   // held entry waits for its data_ok
      ST_HAVE = 2'd2    // response arrived, data parked in the buffer
   } state_t;

   // Per-entry control fields latched from execute
   typedef struct packed {
      logic            mem_req;
      logic            mem_we;
      logic [DS_W-1:0] data_src;
      logic            wdata_src;
      logic [1:0]      addr_low2;
      logic            regs_we;
      logic            excep_en;
   } ctrl_t;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Selects the addressed byte/half lane of load data and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   rdata     raw word returned by the data SRAM (or the parked copy)
//   addr_low2 low address bits selecting the lane
//   data_src  {byte, half, unsigned} width code
//   result    extended value for the register file
module load_extend
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        addr_low2,
   input  logic [DS_W-1:0]   data_src,
   output logic [DATA_W-1:0] result
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic        sign_b;
   logic        sign_h;

   always_comb begin
      lane_b = rdata[7:0];
      case (addr_low2)
         2'd0:    lane_b = rdata[7:0];
         2'd1:    lane_b = rdata[15:8];
         2'd2:    lane_b = rdata[23:16];
         2'd3:    lane_b = rdata[31:24];
         default: lane_b = rdata[7:0];
      endcase
      lane_h = addr_low2[1] ? rdata[31:16] : rdata[15:0];
      sign_b = !data_src[DS_UNSIGNED] && lane_b[7];
      sign_h = !data_src[DS_UNSIGNED] && lane_h[15];

      result = rdata;
      if (data_src[DS_BYTE]) begin
         result = {{(DATA_W-8){sign_b}}, lane_b};
      end else if (data_src[DS_HALF]) begin
         result = {{(DATA_W-16){sign_h}}, lane_h};
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: holds one execute result, waits for its data-SRAM response.
// Latency: 0 cycles for non-memory entries and for a load whose data_ok meets wb_allowin.
// Backpressure: mem_allowin_o drops while the held entry waits for data_ok or writeback stalls.
//
// Optional build macro MEM_LOAD_FWD_EN: when defined, forwarding treats load
// data as available in the data_ok cycle itself instead of one cycle later.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ex_*                     entry from execute, latched on ex_to_mem_valid_i && mem_allowin_o
//   mem_allowin_o            stage can take a new entry
//   data_sram_data_ok_i/_rdata_i  in-order responses to previously accepted requests
//   wb_allowin_i, excep_flush_i   writeback handshake and pipeline flush
//   mem_to_wb_valid_o, wb_*  result toward writeback
//   mem_stall_o              held entry carries an exception
//   fwd_*                    bypass toward decode; fwd_stall_o when load data not yet usable
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int PC_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ex_to_mem_valid_i,
   output logic               mem_allowin_o,
   input  logic               ex_mem_req_i,
   input  logic               ex_mem_we_i,
   input  logic [DS_W-1:0]    ex_data_src_i,
   input  logic               ex_regs_wdata_src_i,
   input  logic [1:0]         ex_addr_low2_i,
   input  logic               ex_regs_we_i,
   input  logic [RADDR_W-1:0] ex_regs_waddr_i,
   input  logic [DATA_W-1:0]  ex_regs_wdata_i,
   input  logic [PC_W-1:0]    ex_pc_i,
   input  logic               ex_excep_en_i,
   input  logic               data_sram_data_ok_i,
   input  logic [DATA_W-1:0]  data_sram_rdata_i,
   input  logic               wb_allowin_i,
   input  logic               excep_flush_i,
   output logic               mem_to_wb_valid_o,
   output logic               wb_regs_we_o,
   output logic [RADDR_W-1:0] wb_regs_waddr_o,
   output logic [DATA_W-1:0]  wb_regs_wdata_o,
   output logic [PC_W-1:0]    wb_pc_o,
   output logic               wb_excep_en_o,
   output logic               mem_stall_o,
   output logic               fwd_we_o,
   output logic [RADDR_W-1:0] fwd_waddr_o,
   output logic [DATA_W-1:0]  fwd_wdata_o,
   output logic               fwd_stall_o
);

   logic                 valid;
   ctrl_t                ctrl;
   logic [RADDR_W-1:0]   waddr;
   logic [DATA_W-1:0]    wdata;
   logic [PC_W-1:0]      pc;
   logic [DATA_W-1:0]    rdata_buf;
   logic [DISCARD_W-1:0] discard_cnt;
   state_t               state;
   state_t               next_state;

   logic                 discarding;
   logic                 own_ok;
   logic                 stale_ok;
   logic                 ready_go;
   logic                 handoff;
   logic                 load_en;
   logic                 cnt_inc;
   logic [DATA_W-1:0]    load_src;
   logic [DATA_W-1:0]    load_ext;
   logic [DATA_W-1:0]    reg_data;

   // A data_ok belongs to the held entry only once every response owed to
   // flushed entries has drained; responses return strictly in order.
   assign discarding = (discard_cnt != DISCARD_ZERO);
   assign own_ok     = data_sram_data_ok_i && !discarding;
   assign stale_ok   = data_sram_data_ok_i && discarding;

   assign ready_go = !ctrl.mem_req || (state == ST_HAVE) ||
                     ((state == ST_WAIT) && own_ok);
   assign handoff  = valid && ready_go && wb_allowin_i;

   assign mem_allowin_o = !valid || (ready_go && wb_allowin_i);
   assign load_en       = ex_to_mem_valid_i && mem_allowin_o && !excep_flush_i;

   // Flushing a waiting entry leaves its response in flight; if a stale
   // response lands in the same cycle the increment and decrement cancel.
   assign cnt_inc = excep_flush_i && (state == ST_WAIT) && !own_ok;

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (load_en && ex_mem_req_i) next_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (own_ok) begin
               if (wb_allowin_i) next_state = (load_en && ex_mem_req_i) ? ST_WAIT : ST_IDLE;
               else              next_state = ST_HAVE;
            end
         end
         ST_HAVE: begin
            if (wb_allowin_i) next_state = (load_en && ex_mem_req_i) ? ST_WAIT : ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
      if (excep_flush_i) next_state = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         ctrl  <= '0;
         waddr <= '0;
         wdata <= '0;
         pc    <= '0;
      end else if (excep_flush_i) begin
         valid <= 1'b0;
      end else if (load_en) begin
         valid          <= 1'b1;
         ctrl.mem_req   <= ex_mem_req_i;
         ctrl.mem_we    <= ex_mem_we_i;
         ctrl.data_src  <= ex_data_src_i;
         ctrl.wdata_src <= ex_regs_wdata_src_i;
         ctrl.addr_low2 <= ex_addr_low2_i;
         ctrl.regs_we   <= ex_regs_we_i;
         ctrl.excep_en  <= ex_excep_en_i;
         waddr          <= ex_regs_waddr_i;
         wdata          <= ex_regs_wdata_i;
         pc             <= ex_pc_i;
      end else if (handoff) begin
         valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         discard_cnt <= DISCARD_ZERO;
      end else begin
         case ({cnt_inc, stale_ok})
            2'b10:   if (discard_cnt != DISCARD_MAX) discard_cnt <= discard_cnt + DISCARD_ONE;
            2'b01:   discard_cnt <= discard_cnt - DISCARD_ONE;
            default: discard_cnt <= discard_cnt;
         endcase
      end
   end

   // Park load data so a stalled writeback does not lose it; stores return nothing useful.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_buf <= '0;
      end else if ((state == ST_WAIT) && own_ok && !ctrl.mem_we) begin
         rdata_buf <= data_sram_rdata_i;
      end
   end

   assign load_src = (state == ST_HAVE) ? rdata_buf : data_sram_rdata_i;

   load_extend #(
      .DATA_W (DATA_W)
   ) u_load_extend (
      .rdata     (load_src),
      .addr_low2 (ctrl.addr_low2),
      .data_src  (ctrl.data_src),
      .result    (load_ext)
   );

   assign reg_data = ctrl.wdata_src ? load_ext : wdata;

   assign mem_to_wb_valid_o = valid && ready_go;
   assign wb_regs_we_o      = ctrl.regs_we && valid && !ctrl.excep_en && !excep_flush_i;
   assign wb_regs_waddr_o   = waddr;
   assign wb_regs_wdata_o   = reg_data;
   assign wb_pc_o           = pc;
   assign wb_excep_en_o     = valid && ctrl.excep_en;
   assign mem_stall_o       = valid && ctrl.excep_en;

   assign fwd_we_o    = valid && ctrl.regs_we;
   assign fwd_waddr_o = waddr;
   assign fwd_wdata_o = reg_data;

`ifdef MEM_LOAD_FWD_EN
   // Load data is usable for bypass in the very cycle it returns.
   assign fwd_stall_o = valid && ctrl.wdata_src && (state != ST_HAVE) &&
                        !((state == ST_WAIT) && own_ok);
`else
   // Bypass waits for the registered copy to avoid a long SRAM-to-decode path.
   assign fwd_stall_o = valid && ctrl.wdata_src && (state != ST_HAVE);
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, buffering, ALU pass-through, flush discard,
// exceptions, back-to-back loads and asynchronous reset.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_to_mem_valid;
   logic        mem_allowin;
   logic        ex_mem_req;
   logic        ex_mem_we;
   logic [2:0]  ex_data_src;
   logic        ex_regs_wdata_src;
   logic [1:0]  ex_addr_low2;
   logic        ex_regs_we;
   logic [4:0]  ex_regs_waddr;
   logic [31:0] ex_regs_wdata;
   logic [31:0] ex_pc;
   logic        ex_excep_en;
   logic        data_ok;
   logic [31:0] rdata;
   logic        wb_allowin;
   logic        excep_flush;
   logic        mem_to_wb_valid;
   logic        wb_regs_we;
   logic [4:0]  wb_regs_waddr;
   logic [31:0] wb_regs_wdata;
   logic [31:0] wb_pc;
   logic        wb_excep_en;
   logic        mem_stall;
   logic        fwd_we;
   logic [4:0]  fwd_waddr;
   logic [31:0] fwd_wdata;
   logic        fwd_stall;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk                 (clk),
      .rst                 (rst),
      .ex_to_mem_valid_i   (ex_to_mem_valid),
      .mem_allowin_o       (mem_allowin),
      .ex_mem_req_i        (ex_mem_req),
      .ex_mem_we_i         (ex_mem_we),
      .ex_data_src_i       (ex_data_src),
      .ex_regs_wdata_src_i (ex_regs_wdata_src),
      .ex_addr_low2_i      (ex_addr_low2),
      .ex_regs_we_i        (ex_regs_we),
      .ex_regs_waddr_i     (ex_regs_waddr),
      .ex_regs_wdata_i     (ex_regs_wdata),
      .ex_pc_i             (ex_pc),
      .ex_excep_en_i       (ex_excep_en),
      .data_sram_data_ok_i (data_ok),
      .data_sram_rdata_i   (rdata),
      .wb_allowin_i        (wb_allowin),
      .excep_flush_i       (excep_flush),
      .mem_to_wb_valid_o   (mem_to_wb_valid),
      .wb_regs_we_o        (wb_regs_we),
      .wb_regs_waddr_o     (wb_regs_waddr),
      .wb_regs_wdata_o     (wb_regs_wdata),
      .wb_pc_o             (wb_pc),
      .wb_excep_en_o       (wb_excep_en),
      .mem_stall_o         (mem_stall),
      .fwd_we_o            (fwd_we),
      .fwd_waddr_o         (fwd_waddr),
      .fwd_wdata_o         (fwd_wdata),
      .fwd_stall_o         (fwd_stall)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ex_to_mem_valid   = 1'b0;
      ex_mem_req        = 1'b0;
      ex_mem_we         = 1'b0;
      ex_data_src       = 3'b000;
      ex_regs_wdata_src = 1'b0;
      ex_addr_low2      = 2'b00;
      ex_regs_we        = 1'b0;
      ex_regs_waddr     = 5'd0;
      ex_regs_wdata     = 32'h0;
      ex_pc             = 32'h0;
      ex_excep_en       = 1'b0;
      data_ok           = 1'b0;
      rdata             = 32'h0;
      excep_flush       = 1'b0;
   endtask

   task automatic present(input logic req, input logic [2:0] src, input logic wsrc,
                          input logic [1:0] a2, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [31:0] pc, input logic exc);
      ex_to_mem_valid   = 1'b1;
      ex_mem_req        = req;
      ex_mem_we         = 1'b0;
      ex_data_src       = src;
      ex_regs_wdata_src = wsrc;
      ex_addr_low2      = a2;
      ex_regs_we        = 1'b1;
      ex_regs_waddr     = wa;
      ex_regs_wdata     = wd;
      ex_pc             = pc;
      ex_excep_en       = exc;
   endtask

   task automatic test_reset();
      idle_inputs();
      wb_allowin = 1'b1;
      #3;
      n_tests++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL rst_allowin: got %b exp 1", mem_allowin); end
      n_tests++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", mem_to_wb_valid); end
      n_tests++; if ({wb_regs_we, mem_stall, fwd_we, fwd_stall, wb_excep_en} !== 5'b0) begin
         n_fail++; $display("FAIL rst_flags: got %b exp 00000", {wb_regs_we, mem_stall, fwd_we, fwd_stall, wb_excep_en}); end
      n_tests++; if (wb_regs_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h exp 0", wb_regs_wdata); end
      #4 rst = 1'b0;
      step();
   endtask

   task automatic test_load_byte();
      present(1'b1, 3'b100, 1'b1, 2'b11, 5'd5, 32'h0, 32'h100, 1'b0);
      step();
      idle_inputs();
      #1;
      n_tests++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL ldb_wait_valid: got %b exp 0", mem_to_wb_valid); end
      n_tests++; if (fwd_stall !== 1'b1) begin n_fail++; $display("FAIL ldb_wait_fwd_stall: got %b exp 1", fwd_stall); end
      n_tests++; if (mem_allowin !== 1'b0) begin n_fail++; $display("FAIL ldb_wait_allowin: got %b exp 0", mem_allowin); end
      data_ok = 1'b1; rdata = 32'h80AB_CD12;
      #1;
      n_tests++; if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL ldb_valid: got %b exp 1", mem_to_wb_valid); end
      n_tests++; if (wb_regs_wdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL ldb_wdata: got %h exp ffffff80", wb_regs_wdata); end
      n_tests++; if ({wb_regs_we, wb_regs_waddr} !== {1'b1, 5'd5}) begin n_fail++; $display("FAIL ldb_we_waddr: got %b/%0d exp 1/5", wb_regs_we, wb_regs_waddr); end
      n_tests++; if (wb_pc !== 32'h100) begin n_fail++; $display("FAIL ldb_pc: got %h exp 100", wb_pc); end
      step();
      idle_inputs();
      #1;
      n_tests++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL ldb_one_cycle: got %b exp 0", mem_to_wb_valid); end
   endtask

   task automatic test_load_half_buffered();
      present(1'b1, 3'b011, 1'b1, 2'b10, 5'd6, 32'h0, 32'h104, 1'b0);
      step();
      idle_inputs();
      wb_allowin = 1'b0;
      data_ok = 1'b1; rdata = 32'h8765_4321;
      #1;
      n_tests++; if (fwd_stall !== 1'b1) begin n_fail++; $display("FAIL ldhu_ok_fwd_stall: got %b exp 1", fwd_stall); end
      n_tests++; if (mem_allowin !== 1'b0) begin n_fail++; $display("FAIL ldhu_ok_allowin: got %b exp 0", mem_allowin); end
      step();
      data_ok = 1'b0; rdata = 32'h0;
      #1;
      n_tests++; if (wb_regs_wdata !== 32'h0000_8765) begin n_fail++; $display("FAIL ldhu_buf_wdata: got %h exp 00008765", wb_regs_wdata); end
      n_tests++; if (fwd_stall !== 1'b0) begin n_fail++; $display("FAIL ldhu_buf_fwd_stall: got %b exp 0", fwd_stall); end
      n_tests++; if (fwd_wdata !== 32'h0000_8765) begin n_fail++; $display("FAIL ldhu_fwd_wdata: got %h exp 00008765", fwd_wdata); end
      step();
      #1;
      n_tests++; if ({mem_to_wb_valid, mem_allowin} !== 2'b10) begin n_fail++; $display("FAIL ldhu_hold: got %b exp 10", {mem_to_wb_valid, mem_allowin}); end
      step();
      wb_allowin = 1'b1;
      #1;
      n_tests++; if (wb_regs_wdata !== 32'h0000_8765) begin n_fail++; $display("FAIL ldhu_out_wdata: got %h exp 00008765", wb_regs_wdata); end
      n_tests++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL ldhu_out_allowin: got %b exp 1", mem_allowin); end
      step();
      #1;
      n_tests++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL ldhu_done: got %b exp 0", mem_to_wb_valid); end
   endtask

   task automatic test_alu();
      present(1'b0, 3'b000, 1'b0, 2'b00, 5'd7, 32'h1234, 32'h108, 1'b0);
      step();
      idle_inputs();
      #1;
      n_tests++; if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b exp 1", mem_to_wb_valid); end
      n_tests++; if (wb_regs_wdata !== 32'h1234) begin n_fail++; $display("FAIL alu_wdata: got %h exp 1234", wb_regs_wdata); end
      n_tests++; if ({fwd_stall, fwd_we, fwd_waddr} !== {1'b0, 1'b1, 5'd7}) begin
         n_fail++; $display("FAIL alu_fwd: got %b/%b/%0d exp 0/1/7", fwd_stall, fwd_we, fwd_waddr); end
      step();
      #1;
      n_tests++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_gone: got %b exp 0", mem_to_wb_valid); end
   endtask

   task automatic test_flush_discard();
      present(1'b1, 3'b000, 1'b1, 2'b00, 5'd8, 32'h0, 32'h10C, 1'b0);
      step();
      idle_inputs();
      excep_flush = 1'b1;
      #1;
      n_tests++; if (wb_regs_we !== 1'b0) begin n_fail++; $display("FAIL flush_we: got %b exp 0", wb_regs_we); end
      step();
      excep_flush = 1'b0;
      #1;
      n_tests++; if ({mem_allowin, mem_to_wb_valid} !== 2'b10) begin n_fail++; $display("FAIL flush_cleared: got %b exp 10", {mem_allowin, mem_to_wb_valid}); end
      present(1'b1, 3'b000, 1'b1, 2'b00, 5'd9, 32'h0, 32'h110, 1'b0);
      step();
      idle_inputs();
      data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
      #1;
      n_tests++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL discard_valid: got %b exp 0", mem_to_wb_valid); end
      n_tests++; if (fwd_stall !== 1'b1) begin n_fail++; $display("FAIL discard_fwd_stall: got %b exp 1", fwd_stall); end
      step();
      data_ok = 1'b0; rdata = 32'h0;
      #1;
      n_tests++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL discard_after: got %b exp 0", mem_to_wb_valid); end
      step();
      data_ok = 1'b1; rdata = 32'hCAFE_F00D;
      #1;
      n_tests++; if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL own_valid: got %b exp 1", mem_to_wb_valid); end
      n_tests++; if ({wb_regs_wdata, wb_regs_waddr} !== {32'hCAFE_F00D, 5'd9}) begin
         n_fail++; $display("FAIL own_data: got %h/%0d exp cafef00d/9", wb_regs_wdata, wb_regs_waddr); end
      step();
      idle_inputs();
   endtask

   task automatic test_exception();
      present(1'b0, 3'b000, 1'b0, 2'b00, 5'd3, 32'h5, 32'h200, 1'b1);
      step();
      idle_inputs();
      #1;
      n_tests++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL exc_stall: got %b exp 1", mem_stall); end
      n_tests++; if (wb_regs_we !== 1'b0) begin n_fail++; $display("FAIL exc_we: got %b exp 0", wb_regs_we); end
      n_tests++; if ({wb_excep_en, mem_to_wb_valid} !== 2'b11) begin n_fail++; $display("FAIL exc_pass: got %b exp 11", {wb_excep_en, mem_to_wb_valid}); end
      step();
      #1;
      n_tests++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL exc_gone: got %b exp 0", mem_stall); end
   endtask

   task automatic test_back_to_back();
      present(1'b1, 3'b000, 1'b1, 2'b00, 5'd10, 32'h0, 32'h300, 1'b0);
      step();
      present(1'b1, 3'b010, 1'b1, 2'b00, 5'd11, 32'h0, 32'h304, 1'b0);
      data_ok = 1'b1; rdata = 32'h1122_3344;
      #1;
      n_tests++; if ({mem_to_wb_valid, mem_allowin} !== 2'b11) begin n_fail++; $display("FAIL b2b_zero_bubble: got %b exp 11", {mem_to_wb_valid, mem_allowin}); end
      n_tests++; if (wb_regs_wdata !== 32'h1122_3344) begin n_fail++; $display("FAIL b2b_word: got %h exp 11223344", wb_regs_wdata); end
      step();
      idle_inputs();
      #1;
      n_tests++; if ({mem_to_wb_valid, fwd_stall, fwd_waddr} !== {1'b0, 1'b1, 5'd11}) begin
         n_fail++; $display("FAIL b2b_second_wait: got %b/%b/%0d exp 0/1/11", mem_to_wb_valid, fwd_stall, fwd_waddr); end
      data_ok = 1'b1; rdata = 32'h5566_9ABC;
      #1;
      n_tests++; if (wb_regs_wdata !== 32'hFFFF_9ABC) begin n_fail++; $display("FAIL b2b_half_signed: got %h exp ffff9abc", wb_regs_wdata); end
      step();
      idle_inputs();
   endtask

   task automatic test_rst_mid_wait();
      present(1'b1, 3'b000, 1'b1, 2'b00, 5'd12, 32'h0, 32'h400, 1'b0);
      step();
      idle_inputs();
      #1;
      n_tests++; if (fwd_stall !== 1'b1) begin n_fail++; $display("FAIL arst_pre_wait: got %b exp 1", fwd_stall); end
      rst = 1'b1;
      #1;
      n_tests++; if ({mem_allowin, mem_to_wb_valid, fwd_stall, fwd_we} !== 4'b1000) begin
         n_fail++; $display("FAIL arst_outputs: got %b exp 1000", {mem_allowin, mem_to_wb_valid, fwd_stall, fwd_we}); end
      n_tests++; if ({wb_regs_waddr, wb_pc} !== {5'd0, 32'h0}) begin n_fail++; $display("FAIL arst_regs: got %0d/%h exp 0/0", wb_regs_waddr, wb_pc); end
      #2 rst = 1'b0;
      step();
      present(1'b0, 3'b000, 1'b0, 2'b00, 5'd13, 32'h77, 32'h404, 1'b0);
      step();
      idle_inputs();
      #1;
      n_tests++; if ({mem_to_wb_valid, wb_regs_wdata} !== {1'b1, 32'h77}) begin
         n_fail++; $display("FAIL arst_recover: got %b/%h exp 1/77", mem_to_wb_valid, wb_regs_wdata); end
      step();
   endtask

   initial begin
      test_reset();
      test_load_byte();
      test_load_half_buffered();
      test_alu();
      test_flush_discard();
      test_exception();
      test_back_to_back();
      test_rst_mid_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
